// File: rtl/debug_trace_serializer_if.sv
// debug_trace_serializer_if: write-back debug bus in, nibble-serial trace out.
// Carries debug_wb_pc/instr/rf_wdata and mode toward the serializer.
// Carries data/data_valid/frame_start/overflow_cnt back from it.
interface debug_trace_serializer_if #(parameter int CNT_W = 8);
  logic [31:0] debug_wb_pc;
  logic [31:0] debug_wb_instr;
  logic [31:0] debug_wb_rf_wdata;
  logic [1:0] mode;
  logic [3:0] data;
  logic data_valid;
  logic frame_start;
  logic [CNT_W-1:0] overflow_cnt;
  modport master (
    output debug_wb_pc, debug_wb_instr, debug_wb_rf_wdata, mode,
    input data, data_valid, frame_start, overflow_cnt
  );
  modport slave (
    input debug_wb_pc, debug_wb_instr, debug_wb_rf_wdata, mode,
    output data, data_valid, frame_start, overflow_cnt
  );
endinterface

// File: rtl/debug_trace_serializer.sv
// debug_trace_serializer: buffers retired commit records and streams them as nibble frames.
// Ports: aclk (CPU clock), aresetn (async active-low reset), bus (slave side of
// debug_trace_serializer_if: write-back debug bus and mode in; data, data_valid,
// frame_start and saturating overflow_cnt out).
module debug_trace_serializer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic aclk,
  input logic aresetn,
  debug_trace_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [95:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] last_pc;
  logic [95:0] sr;
  logic [1:0] fmode;
  logic [4:0] nib_cnt;
  logic [CNT_W-1:0] ovf;
  logic empty, full, cap, load, flush, push, drop;
  logic [3:0] data;
  logic data_valid, frame_start;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign cap = bus.mode != 2'd0 && bus.debug_wb_pc != last_pc;
  assign load = state == IDLE && !empty && bus.mode != 2'd0;
  assign flush = state == IDLE && !empty && bus.mode == 2'd0;
  // a pop on the same edge frees the slot, so a full FIFO still accepts the record
  assign push = cap && (!full || load);
  assign drop = cap && full && !load;
  always_comb begin
    state_nx = state;
    data = 4'h0;
    data_valid = 1'b0;
    frame_start = 1'b0;
    if (state == IDLE) begin
      state_nx = load ? SHIFT : IDLE;
    end else begin
      data = sr[95:92];
      data_valid = 1'b1;
      // nib_cnt still holds its load value only on the first nibble
      frame_start = nib_cnt == {fmode, 3'b000} - 5'd1;
      state_nx = nib_cnt == 5'd0 ? IDLE : SHIFT;
    end
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge aclk)
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.debug_wb_pc, bus.debug_wb_instr, bus.debug_wb_rf_wdata};
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_pc <= '0;
      sr <= '0;
      fmode <= 2'd0;
      nib_cnt <= 5'd0;
      ovf <= '0;
    end else begin
      last_pc <= bus.debug_wb_pc;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= flush ? wr_ptr : load ? rd_ptr + 1'b1 : rd_ptr;
      if (drop && ovf != '1) ovf <= ovf + 1'b1;
      if (load) begin
        sr <= mem[rd_ptr[AW-1:0]];
        fmode <= bus.mode;
        nib_cnt <= {bus.mode, 3'b000} - 5'd1;
      end else if (state == SHIFT) begin
        sr <= sr << 4;
        nib_cnt <= nib_cnt - 5'd1;
      end
    end
  end
  assign bus.data = data;
  assign bus.data_valid = data_valid;
  assign bus.frame_start = frame_start;
  assign bus.overflow_cnt = ovf;
endmodule

// File: tb/tb_debug_trace_serializer.sv
// tb_debug_trace_serializer: directed vector table plus multi-cycle sequences for the serializer.
module tb_debug_trace_serializer;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int nvec = 0;
  int nerr = 0;
  always #5 aclk = ~aclk;
  debug_trace_serializer_if #(.CNT_W(8)) ifc ();
  debug_trace_serializer #(.DEPTH(4), .CNT_W(8)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(ifc.slave)
  );
  typedef struct {
    logic [1:0] mode;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic [95:0] frame;
    int len;
  } vec_t;
  vec_t vt [5];
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] m, input logic [31:0] p, input logic [31:0] i, input logic [31:0] w);
    ifc.mode = m;
    ifc.debug_wb_pc = p;
    ifc.debug_wb_instr = i;
    ifc.debug_wb_rf_wdata = w;
  endtask
  // waits up to max_wait cycles for a frame, then gathers it left-justified into val
  task automatic collect(input int max_wait, output bit found, output int lat,
                         output logic [95:0] val, output int len, output bit fs_ok);
    int fs_cnt;
    bit fs_first;
    found = 1'b0;
    lat = 0;
    val = '0;
    len = 0;
    fs_cnt = 0;
    fs_first = 1'b0;
    fs_ok = 1'b0;
    while (!ifc.data_valid && lat < max_wait) begin
      tick();
      lat++;
    end
    if (!ifc.data_valid) return;
    found = 1'b1;
    fs_first = ifc.frame_start;
    while (ifc.data_valid && len < 30) begin
      if (ifc.frame_start) fs_cnt++;
      val = {val[91:0], ifc.data};
      len++;
      tick();
    end
    if (len > 0 && len <= 24) val = val << (4 * (24 - len));
    fs_ok = fs_first && fs_cnt == 1;
  endtask
  task automatic wait_fs();
    int n = 0;
    while (!ifc.frame_start && n < 30) begin
      tick();
      n++;
    end
    chk("frame_start_seen", {95'd0, ifc.frame_start}, 96'd1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bit found, fs_ok;
    int lat, len;
    logic [95:0] val;
    logic [31:0] pcs [6];
    vt[0] = '{2'd1, 32'h1c000000, 32'h11111111, 32'h22222222, 96'h1c000000_00000000_00000000, 8};
    vt[1] = '{2'd3, 32'h1c000004, 32'h02800c0c, 32'hdeadbeef, 96'h1c000004_02800c0c_deadbeef, 24};
    vt[2] = '{2'd2, 32'h80001230, 32'h12345678, 32'hcafef00d, 96'h80001230_12345678_00000000, 16};
    vt[3] = '{2'd1, 32'hffffffff, 32'habcdef01, 32'h55555555, 96'hffffffff_00000000_00000000, 8};
    vt[4] = '{2'd3, 32'h00000010, 32'h00a00513, 32'h0000000a, 96'h00000010_00a00513_0000000a, 24};
    pcs = '{32'h1c000100, 32'h1c000104, 32'h1c000108, 32'h1c00010c, 32'h1c000110, 32'h1c000114};
    drive(2'd0, 32'h0, 32'h0, 32'h0);
    repeat (3) tick();
    chk("reset_data_valid", {95'd0, ifc.data_valid}, 96'd0);
    chk("reset_data", {92'd0, ifc.data}, 96'd0);
    chk("reset_frame_start", {95'd0, ifc.frame_start}, 96'd0);
    chk("reset_overflow_cnt", {88'd0, ifc.overflow_cnt}, 96'd0);
    aresetn = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(vt[k].mode, vt[k].pc, vt[k].instr, vt[k].wdata);
      collect(20, found, lat, val, len, fs_ok);
      chk($sformatf("vec%0d_found", k), {95'd0, found}, 96'd1);
      chk($sformatf("vec%0d_latency", k), 96'(lat), 96'd2);
      chk($sformatf("vec%0d_len", k), 96'(len), 96'(vt[k].len));
      chk($sformatf("vec%0d_frame", k), val, vt[k].frame);
      chk($sformatf("vec%0d_frame_start", k), {95'd0, fs_ok}, 96'd1);
      chk($sformatf("vec%0d_idle_data", k), {92'd0, ifc.data}, 96'd0);
    end
    // six PCs back to back into a 4-deep FIFO: one record dropped
    ifc.mode = 2'd2;
    fork
      for (int k = 0; k < 6; k++) begin
        drive(2'd2, pcs[k], 32'h00000013 + 32'(k), 32'h0);
        tick();
      end
      for (int k = 0; k < 5; k++) begin
        bit f, fo;
        int la, le;
        logic [95:0] v;
        collect(30, f, la, v, le, fo);
        chk($sformatf("ovf%0d_len", k), 96'(le), 96'd16);
        chk($sformatf("ovf%0d_frame", k), v, {pcs[k], 32'h00000013 + 32'(k), 32'h0});
        chk($sformatf("ovf%0d_frame_start", k), {95'd0, fo}, 96'd1);
        if (k > 0) chk($sformatf("ovf%0d_gap", k), 96'(la), 96'd1);
      end
    join
    chk("ovf_count", {88'd0, ifc.overflow_cnt}, 96'd1);
    collect(20, found, lat, val, len, fs_ok);
    chk("ovf_no_sixth_frame", {95'd0, found}, 96'd0);
    // mode 3 -> 1 during the 10th nibble of a frame
    fork
      begin
        drive(2'd3, 32'h20000000, 32'h01234567, 32'h89abcdef);
        tick();
        drive(2'd3, 32'h20000004, 32'h0, 32'h0);
        tick();
        wait_fs();
        repeat (9) tick();
        ifc.mode = 2'd1;
      end
      begin
        bit f, fo;
        int la, le;
        logic [95:0] v;
        collect(20, f, la, v, le, fo);
        chk("msw_first_len", 96'(le), 96'd24);
        chk("msw_first_frame", v, 96'h20000000_01234567_89abcdef);
        collect(20, f, la, v, le, fo);
        chk("msw_second_gap", 96'(la), 96'd1);
        chk("msw_second_len", 96'(le), 96'd8);
        chk("msw_second_frame", v, 96'h20000004_00000000_00000000);
      end
    join
    // three records queued, then mode 0: current frame completes, rest flushed
    fork
      begin
        drive(2'd3, 32'h30000000, 32'haaaa0001, 32'hbbbb0001);
        tick();
        drive(2'd3, 32'h30000004, 32'haaaa0002, 32'hbbbb0002);
        tick();
        drive(2'd3, 32'h30000008, 32'haaaa0003, 32'hbbbb0003);
        tick();
        repeat (3) tick();
        ifc.mode = 2'd0;
        for (int k = 0; k < 3; k++) begin
          ifc.debug_wb_pc = 32'h40000000 + 32'(4 * k);
          tick();
        end
      end
      begin
        bit f, fo;
        int la, le;
        logic [95:0] v;
        collect(20, f, la, v, le, fo);
        chk("flush_frame_len", 96'(le), 96'd24);
        chk("flush_frame", v, 96'h30000000_aaaa0001_bbbb0001);
      end
    join
    collect(40, found, lat, val, len, fs_ok);
    chk("flush_no_frame_mode0", {95'd0, found}, 96'd0);
    ifc.mode = 2'd1;
    collect(20, found, lat, val, len, fs_ok);
    chk("flush_no_frame_after_mode1", {95'd0, found}, 96'd0);
    chk("flush_overflow_cnt", {88'd0, ifc.overflow_cnt}, 96'd1);
    // asynchronous reset at the 5th nibble of a frame
    drive(2'd1, 32'h50000000, 32'h0, 32'h0);
    wait_fs();
    repeat (4) tick();
    chk("rst_pre_valid", {95'd0, ifc.data_valid}, 96'd1);
    aresetn = 1'b0;
    ifc.mode = 2'd0;
    #1;
    chk("rst_data_valid", {95'd0, ifc.data_valid}, 96'd0);
    chk("rst_data", {92'd0, ifc.data}, 96'd0);
    chk("rst_overflow_cnt", {88'd0, ifc.overflow_cnt}, 96'd0);
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
    ifc.mode = 2'd1;
    collect(15, found, lat, val, len, fs_ok);
    chk("rst_no_resume", {95'd0, found}, 96'd0);
    drive(2'd1, 32'h50000010, 32'h0, 32'h0);
    collect(20, found, lat, val, len, fs_ok);
    chk("rst_clean_latency", 96'(lat), 96'd2);
    chk("rst_clean_len", 96'(len), 96'd8);
    chk("rst_clean_frame", val, 96'h50000010_00000000_00000000);
    chk("rst_clean_frame_start", {95'd0, fs_ok}, 96'd1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/debug_trace_serializer.md
Name: debug_trace_serializer

Overview:
- Consumes the CPU core's write-back debug bus (debug_wb_pc / debug_wb_instr / debug_wb_rf_wdata) inside the CPU clock domain, downstream of the core in the CPU wrapper.
- Detects each new retired PC, buffers the commit record in a small FIFO, and streams it out as a nibble-serial frame on the 4-bit debug pins.
- Frame content is selected by the 2-bit debug output mode, which arrives already synchronised.

Parameters:
- DEPTH, 4, FIFO entries of 96-bit commit records; power of two, 2..16.
- CNT_W, 8, width of saturating overflow counter.

Ports:
- aclk  input  1  CPU clock; all logic on rising edge.
- aresetn  input  1  asynchronous active-low reset.
- debug_wb_pc  input  32  PC of the instruction at write-back.
- debug_wb_instr  input  32  instruction word at write-back.
- debug_wb_rf_wdata  input  32  register-file write data at write-back.
- mode  input  2  synchronised output mode: 0 off, 1 PC, 2 PC+instr, 3 PC+instr+wdata.
- data  output  4  serial nibble.
- data_valid  output  1  data carries a frame nibble this cycle.
- frame_start  output  1  first nibble of a frame.
- overflow_cnt  output  CNT_W  dropped commit records, saturating.

Behaviour:
- Reset values: data=0, data_valid=0, frame_start=0, overflow_cnt=0, FIFO empty, last_pc=0, FSM=IDLE, shift register=0.
- Capture:
  - Capture event in cycle N when mode!=0 and debug_wb_pc != last_pc.
  - On the N edge, {pc, instr, wdata} is pushed and last_pc <= debug_wb_pc.
  - last_pc also updates when mode==0; no push in that case.
  - A self-loop, where pc is unchanged, produces no new record (accepted limitation).
- Overflow:
  - A capture event with the FIFO full and no pop on the same edge drops the record; overflow_cnt increments, saturating at 2^CNT_W-1.
  - last_pc still updates.
  - Push and pop on the same edge when full: no drop, count unchanged.
- FSM IDLE:
  - data_valid=0, data=0.
  - If FIFO non-empty and mode!=0: pop head into the 96-bit shift register, latch mode into fmode, set nib_cnt = 8*fmode-1, go to SHIFT.
  - If mode==0 and FIFO non-empty: flush FIFO (count -> 0) on that edge; no frame.
- FSM SHIFT:
  - data = shift register [95:92], data_valid=1, frame_start=1 only on the first SHIFT cycle.
  - Each edge: shift left 4, nib_cnt decrements.
  - At nib_cnt==0, go to IDLE.
- Frame order: pc[31:28] first down to pc[3:0], then instr MSB-nibble first, then wdata. Length is 8, 16 or 24 nibbles for fmode 1, 2, 3.
- Mode changes mid-frame do not affect the current frame, which runs on the latched fmode. The new mode applies at the next IDLE decision.
- Latency: pc change presented in cycle N -> push at edge N -> IDLE load at edge N+1 -> first nibble valid in cycle N+2 (data_valid=1, frame_start=1).
- Back-to-back frames: exactly one IDLE cycle (data_valid=0) between consecutive frames.
- Outputs data, data_valid and frame_start are driven combinationally from state and the shift register. No combinational path exists from debug_wb_* to any output.
- Asynchronous reset mid-frame: outputs drop to reset values immediately. No partial frame resumes after reset; the FIFO is emptied.
- FIFO pointers are log2(DEPTH) bits plus a wrap bit; full/empty come from pointer compare. Wrap-around must be seamless.

Test Plan:
- mode=1; pc 0x1c000000 presented one cycle in cycle 5 -> cycles 7..14 data = 1,c,0,0,0,0,0,0; frame_start only in cycle 7; data_valid low in cycle 15.
- mode=3; pc=0x1c000004, instr=0x02800c0c, wdata=0xdeadbeef -> 24 nibbles: 1c000004, then 02800c0c, then deadbeef, in order.
- mode=2; 6 distinct PCs on consecutive cycles, DEPTH=4 -> 5 frames emitted (the first record is popped the cycle after its push, freeing a slot); overflow_cnt=1; each frame has 16 nibbles with one idle cycle between frames.
- mode switched 3->1 during the 10th nibble of a frame -> frame completes 24 nibbles; next frame has 8 nibbles.
- 3 records queued, then mode=0 -> frame in progress finishes; FIFO flushed; no further frames; pc changes while mode=0 push nothing.
- aresetn asserted at nibble 5 of a frame, released 3 cycles later -> data_valid=0 immediately, overflow_cnt=0; next pc change produces a clean frame with frame_start.
